// File: rtl/gcd_sched_pkg.sv
// Shared types and constants for the GCD job scheduler.
// Holds the FSM state enum, operand/result widths and the timeout limit.
`timescale 1ns/1ps
package gcd_sched_pkg;

  localparam int OP_W        = 8;
  localparam int RES_W       = 16;
  localparam int TIMEOUT_CYC = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

endpackage

// File: rtl/gcd_op_fifo.sv
// Operand-pair queue for the GCD scheduler.
// Ports: clk, reset (async, active-high), push/din, pop/dout, full, empty.
`timescale 1ns/1ps
module gcd_op_fifo
  import gcd_sched_pkg::*;
#(
  parameter int WIDTH = 2 * OP_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_job_sched.sv
// Queues operand pairs, issues them to an external GCD engine one at a
// time and presents {a, b, gcd} through a one-entry output slot.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_a/in_b;
// out_valid/out_ready/out_a/out_b/out_gcd; gcd_start/gcd_a/gcd_b;
// gcd_done/gcd_result; busy.
// Build macro GCD_SCHED_TIMEOUT_EN adds a timeout_err output and drops
// a job whose engine has not answered after TIMEOUT_CYC wait cycles.
`timescale 1ns/1ps
module gcd_job_sched
  import gcd_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_a,
  output logic [OP_W-1:0]  out_b,
  output logic [RES_W-1:0] out_gcd,
  output logic             gcd_start,
  output logic [OP_W-1:0]  gcd_a,
  output logic [OP_W-1:0]  gcd_b,
  input  logic             gcd_done,
  input  logic [RES_W-1:0] gcd_result,
`ifdef GCD_SCHED_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output logic             busy
);

  state_t state;
  state_t state_n;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [2*OP_W-1:0] q_dout;
  logic [OP_W-1:0]   sh_a;
  logic [OP_W-1:0]   sh_b;
  logic              slot_free;
  logic              capture;

  // in_ready comes from the registered count, so a full queue stays
  // not-ready even in a cycle that also pops.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign gcd_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  gcd_op_fifo #(
    .WIDTH (2 * OP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({in_a, in_b}),
    .pop   (pop),
    .dout  (q_dout),
    .full  (full),
    .empty (empty)
  );

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          tmo_fire;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_fire) begin
        timeout_err <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    capture = 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
    tmo_fire = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (!empty && gcd_done) begin
          pop     = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (gcd_done) begin
          if (slot_free) begin
            capture = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_HOLD;
          end
        end
`ifdef GCD_SCHED_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_n  = S_IDLE;
        end
`endif
      end
      S_HOLD: begin
        // The engine keeps gcd_result stable while idle.
        if (slot_free) begin
          capture = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcd_a <= '0;
      gcd_b <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
    end else if (pop) begin
      gcd_a <= q_dout[2*OP_W-1:OP_W];
      gcd_b <= q_dout[OP_W-1:0];
      sh_a  <= q_dout[2*OP_W-1:OP_W];
      sh_b  <= q_dout[OP_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_gcd   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_a     <= sh_a;
      out_b     <= sh_b;
      out_gcd   <= gcd_result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_job_sched.sv
// Randomized self-checking bench for gcd_job_sched with a behavioural
// GCD engine and an in-order result scoreboard.
`timescale 1ns/1ps
module tb_gcd_job_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [15:0] out_gcd;
  logic        gcd_start;
  logic [7:0]  gcd_a;
  logic [7:0]  gcd_b;
  logic        gcd_done;
  logic [15:0] gcd_result;
  logic        busy;
`ifdef GCD_SCHED_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  gcd_job_sched #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_gcd    (out_gcd),
    .gcd_start  (gcd_start),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
`ifdef GCD_SCHED_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy       (busy)
  );

  int n_chk = 0;
  int n_bad = 0;
  int n_out = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_gcd(input logic [7:0] a,
                                          input logic [7:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 16'(x);
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  pair_t sb[$];

  // Behavioural engine: idle with done=1, drops done for a few cycles
  // after each start, then holds the result until the next start.
  int         eng_lat = 3;
  bit         eng_rand = 0;
  bit         eng_hang = 0;
  int         eng_cnt;
  logic [7:0] ea;
  logic [7:0] eb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      gcd_done   <= 1'b1;
      gcd_result <= '0;
      eng_cnt    <= 0;
    end else if (gcd_start) begin
      gcd_done <= 1'b0;
      ea       <= gcd_a;
      eb       <= gcd_b;
      eng_cnt  <= eng_rand ? int'($urandom_range(1, 6)) : eng_lat;
    end else if (!gcd_done && !eng_hang) begin
      if (eng_cnt <= 1) begin
        gcd_done   <= 1'b1;
        gcd_result <= ref_gcd(ea, eb);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // 0: out_ready low, 1: high, 2: random each cycle.
  int rdy_mode = 1;

  initial begin
    forever begin
      @(negedge clk);
      unique case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: sampled mid-low-phase, after drivers have settled.
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    pair_t e;
    #2;
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_a, out_b, out_gcd}, pd);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_gcd", out_gcd, ref_gcd(e.a, e.b));
          n_out++;
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = {out_a, out_b, out_gcd};
    end
  end

  // Called right after a negedge; returns right after the next negedge
  // following the accepting clock edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    pair_t p;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      chk("push_timeout", 0, 1);
    end else begin
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      p.a = a;
      p.b = b;
      sb.push_back(p);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(tag, 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sb.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    logic seen;
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gcd_start", gcd_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {out_a, out_b, out_gcd}, 0);
    chk("rst_gcd_ab", {gcd_a, gcd_b}, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef GCD_SCHED_TIMEOUT_EN
    chk("rst_timeout", timeout_err, 0);
`endif
    #1 reset = 1'b0;
    @(negedge clk);

    // (48,18): accepted in cycle c, gcd_start high in cycle c+2.
    rdy_mode = 1;
    push(8'd48, 8'd18);
    chk("lat_start_early", gcd_start, 0);
    @(negedge clk);
    chk("lat_start", gcd_start, 1);
    chk("lat_gcd_a", gcd_a, 48);
    chk("lat_gcd_b", gcd_b, 18);
    wait_valid("wait_48_18");
    chk("res_48_18", out_gcd, 6);
    wait_drain("drain_48_18");

    // Zero operands, back-to-back: next start right after capture.
    push(8'd0, 8'd5);
    push(8'd7, 8'd0);
    wait_valid("wait_0_5");
    chk("zero_res_first", out_gcd, 5);
    @(negedge clk);
    chk("b2b_start", gcd_start, 1);
    chk("b2b_gcd_a", gcd_a, 7);
    wait_drain("drain_zero");

    // Stalled output: slot full, one job held, queue full.
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      push(8'(12 * (i + 1)), 8'(8 + i));
    end
    repeat (20) @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_busy", busy, 1);
    chk("stall_valid", out_valid, 1);
    chk("stall_sb", 32'(sb.size()), 6);
    base = n_out;
    rdy_mode = 1;
    wait_drain("drain_stall");
    chk("stall_count", 32'(n_out - base), 6);

    // Randomized traffic.
    eng_rand = 1;
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      push(ra, rb);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rdy_mode = 1;
    wait_drain("drain_rand");

    // Reset mid-job with three pairs queued.
    eng_rand = 0;
    eng_lat = 20;
    for (int i = 0; i < 4; i++) begin
      push(8'(30 + i), 8'(6 + i));
    end
    chk("mid_busy", busy, 1);
    chk("mid_wait", gcd_done, 0);
    #1 reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_gcd_start", gcd_start, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_outs", {out_a, out_b, out_gcd}, 0);
    chk("mrst_gcd_ab", {gcd_a, gcd_b}, 0);
    chk("mrst_in_ready", in_ready, 1);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | out_valid | gcd_start;
    end
    chk("mrst_quiet", seen, 0);
    eng_lat = 3;
    push(8'd100, 8'd75);
    push(8'd17, 8'd51);
    wait_drain("drain_after_rst");

`ifdef GCD_SCHED_TIMEOUT_EN
    // Engine never answers: job dropped after 32 wait cycles.
    eng_hang = 1;
    push(8'd9, 8'd3);
    begin
      int n = 0;
      while (!gcd_start && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("to_start", gcd_start, 1);
    end
    repeat (32) @(negedge clk);
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy_wait", busy, 1);
    @(negedge clk);
    chk("to_err", timeout_err, 1);
    chk("to_idle", busy, 0);
    chk("to_no_valid", out_valid, 0);
    sb.delete();
    repeat (5) @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    chk("to_still_none", out_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
